dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory interface. It accepts load/store requests over a valid/ready request channel and performs byte, halfword and word accesses into an internal word-organised RAM.
- It inserts a programmable number of wait states, then returns read data or a status on a valid/ready response channel.
- It is the responder counterpart of the datapath's address/write-data/read-data port, for the multi-cycle core and for bench memory models.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access-size encodings,
// responder FSM states and the wait-state counter width.
package dmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between a data-memory requester (master) and
// the dmem_responder (slave).
interface dmem_responder_if;

  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rdata;
  logic        o_err;

  modport master (
    output i_req_valid, i_we, i_addr, i_wdata, i_size, i_unsigned, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rdata, o_err
  );

  modport slave (
    input  i_req_valid, i_we, i_addr, i_wdata, i_size, i_unsigned, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rdata, o_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and lane-replicated write
// data, load lane extraction with sign/zero extension, misalignment flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw_word,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = raw_word[7:0];
      2'd1:    rd_byte = raw_word[15:8];
      2'd2:    rd_byte = raw_word[23:16];
      default: rd_byte = raw_word[31:24];
    endcase
    rd_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    rdata_ext   = raw_word;
    misalign    = 1'b0;
    // Write data is replicated across lanes; the byte enable picks the live one.
    case (size_e'(size))
      SZ_BYTE: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{~is_unsigned & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{~is_unsigned & rd_half[15]}}, rd_half};
        misalign    = addr_lo[0];
      end
      SZ_WORD: begin
        byte_en  = 4'b1111;
        misalign = |addr_lo;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word access and WAIT_CYCLES
// wait states. Define DMEM_B2B_EN to accept a new request on the response handshake.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  dmem_responder_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0]      DEPTH_L = 30'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             rsp_valid_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        do_access;
  logic        err_w;
  logic [31:0] raw_word;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_ext;
  logic        misalign;

`ifdef DMEM_B2B_EN
  assign bus.o_req_ready = ~i_rst & ((state == ST_IDLE) | ((state == ST_RESP) & bus.i_rsp_ready));
`else
  assign bus.o_req_ready = ~i_rst & (state == ST_IDLE);
`endif

  assign accept    = bus.i_req_valid & bus.o_req_ready;
  assign do_access = (state == ST_WAIT) && (cnt == '0);
  assign raw_word  = mem[addr_q[AW+1:2]];
  assign err_w     = misalign | (addr_q[31:2] >= DEPTH_L);

  dmem_lane_align u_lane (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .raw_word    (raw_word),
    .wdata       (wdata_q),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // Counter preloads WAIT_CYCLES so the access edge lands 1+WAIT_CYCLES after accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_WAIT;
            cnt   <= WAIT_L;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= (we_q || err_w) ? '0 : rdata_ext;
            err_q       <= err_w;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
              state <= ST_WAIT;
              cnt   <= WAIT_L;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      we_q    <= bus.i_we;
      addr_q  <= bus.i_addr;
      wdata_q <= bus.i_wdata;
      size_q  <= bus.i_size;
      uns_q   <= bus.i_unsigned;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_access && we_q && !err_w) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model
// that applies the access/lane/error rules arithmetically.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned W     = 2;
`ifdef DMEM_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem_m [int unsigned];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: expected response of one access, updating the model on stores.
  function automatic void model_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [1:0] sz, input logic uns,
                                   output logic [31:0] d, output logic e);
    int unsigned w, lane;
    logic [31:0] cur, v;
    w    = {2'b00, addr[31:2]};
    lane = {30'd0, addr[1:0]};
    e = (sz == 2'b11) || (sz == 2'b01 && lane % 2 != 0) || (sz == 2'b10 && lane != 0) || (w >= DEPTH);
    d = '0;
    if (e) return;
    cur = mem_m[w];
    if (we) begin
      case (sz)
        2'b00:   cur[8*lane +: 8]  = wd[7:0];
        2'b01:   cur[8*lane +: 16] = wd[15:0];
        default: cur = wd;
      endcase
      mem_m[w] = cur;
    end else begin
      case (sz)
        2'b00: begin
          v = (cur >> (8*lane)) & 32'h0000_00FF;
          if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end
        2'b01: begin
          v = (cur >> (8*lane)) & 32'h0000_FFFF;
          if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        default: v = cur;
      endcase
      d = v;
    end
  endfunction

  task automatic scramble();
    bus.i_we       = 1'($urandom);
    bus.i_addr     = $urandom;
    bus.i_wdata    = $urandom;
    bus.i_size     = 2'($urandom);
    bus.i_unsigned = 1'($urandom);
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns);
    bus.i_we       = we;
    bus.i_addr     = addr;
    bus.i_wdata    = wd;
    bus.i_size     = sz;
    bus.i_unsigned = uns;
  endtask

  // Called at a negedge with request fields driven; returns at the negedge after accept.
  task automatic issue();
    int n = 0;
    bus.i_req_valid = 1'b1;
    while (!bus.o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    scramble();
  endtask

  task automatic collect(input logic [31:0] ed, input logic ee, input int hold,
                         input bit ovl, input logic owe, input logic [31:0] oaddr,
                         input logic [31:0] owd, input logic [1:0] osz, input logic ouns,
                         output logic [31:0] got);
    int lat = 0;
    while (!bus.o_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(W + 1));
    chk("rdata", bus.o_rdata, ed);
    chk("err", 32'(bus.o_err), 32'(ee));
    got = bus.o_rdata;
    for (int i = 0; i < hold; i++) begin
      bus.i_req_valid = 1'($urandom);
      scramble();
      @(negedge clk);
      chk("bp_valid", 32'(bus.o_rsp_valid), 32'd1);
      chk("bp_rdata", bus.o_rdata, ed);
      chk("bp_err", 32'(bus.o_err), 32'(ee));
      chk("bp_ready", 32'(bus.o_req_ready), 32'd0);
    end
    bus.i_rsp_ready = 1'b1;
    if (ovl) begin
      drive(owe, oaddr, owd, osz, ouns);
      bus.i_req_valid = 1'b1;
    end else begin
      bus.i_req_valid = 1'b0;
    end
    #1;
    chk("hs_ready", 32'(bus.o_req_ready), 32'(B2B));
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    bus.i_req_valid = 1'b0;
    scramble();
    if (!(ovl && B2B)) chk("hs_valid_clr", 32'(bus.o_rsp_valid), 32'd0);
  endtask

  task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [1:0] sz, input logic uns, input int hold,
                    output logic [31:0] got);
    logic [31:0] ed;
    logic        ee;
    model_op(we, addr, wd, sz, uns, ed, ee);
    drive(we, addr, wd, sz, uns);
    issue();
    collect(ed, ee, hold, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, got);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, ed, ed2;
    logic        ee, ee2;
    logic [31:0] a;
    rst             = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_rsp_ready = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
    chk("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(bus.o_req_ready), 32'd1);
    chk("idle_valid", 32'(bus.o_rsp_valid), 32'd0);

    for (int i = 0; i < 16; i++) op(1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, 0, got);
    op(1'b1, 32'((DEPTH - 1) * 4), $urandom, 2'b10, 1'b0, 0, got);

    op(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, got);
    op(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, got);
    chk("tp_word_ld", got, 32'hDEAD_BEEF);
    op(1'b1, 32'h13, 32'h0000_0080, 2'b00, 1'b0, 0, got);
    op(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, got);
    chk("tp_byte_s", got, 32'hFFFF_FF80);
    op(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, got);
    chk("tp_byte_u", got, 32'h0000_0080);
    op(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, got);
    chk("tp_word_mix", got, 32'h80AD_BEEF);

    op(1'b0, 32'h11, 32'h0, 2'b01, 1'b0, 0, got);
    chk("tp_half_mis", got, 32'h0);
    op(1'b1, 32'h12, 32'h1234_5678, 2'b10, 1'b0, 0, got);
    op(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, got);
    chk("tp_mis_untouched", got, 32'h80AD_BEEF);
    op(1'b1, 32'(DEPTH * 4), 32'hCAFE_F00D, 2'b10, 1'b0, 0, got);
    op(1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 2'b10, 1'b0, 0, got);
    op(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 0, got);
    op(1'b1, 32'h10, 32'h5555_AAAA, 2'b11, 1'b0, 0, got);
    op(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, got);
    chk("tp_oor_untouched", got, 32'h80AD_BEEF);

    // Request presented on the response handshake cycle
    model_op(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, ed, ee);
    drive(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    issue();
    if (B2B) model_op(1'b1, 32'h14, 32'h5A5A_1234, 2'b10, 1'b0, ed2, ee2);
    collect(ed, ee, 1, 1'b1, 1'b1, 32'h14, 32'h5A5A_1234, 2'b10, 1'b0, got);
    if (B2B) begin
      collect(ed2, ee2, 0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0, got);
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk("nob2b_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
        chk("nob2b_idle", 32'(bus.o_req_ready), 32'd1);
        @(negedge clk);
      end
    end
    op(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 0, got);

    // Reset while a store sits in WAIT
    drive(1'b1, 32'h20, 32'hBADC_0FFE, 2'b10, 1'b0);
    issue();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("mid_rst_rdata", bus.o_rdata, 32'd0);
    chk("mid_rst_err", 32'(bus.o_err), 32'd0);
    chk("mid_rst_ready", 32'(bus.o_req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(W) + 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    end
    op(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, got);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(7))
        0:       a = 32'(DEPTH * 4) + ($urandom_range(63) << 2) + 32'($urandom_range(3));
        1:       a = 32'((DEPTH - 1) * 4) + 32'($urandom_range(3));
        default: a = 32'($urandom_range(63));
      endcase
      op(1'($urandom), a, $urandom, ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2)),
         1'($urandom), $urandom_range(2), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
